// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bundle between the writeback arbiter and its requesters/register file.
// Latency: none (wires only).
// Backpressure: a_ready/b_ready driven by the arbiter, requesters hold until accepted.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32
);
    localparam int RW = $clog2(NREG);

    logic            a_valid;
    logic            a_ready;
    logic [RW-1:0]   a_rd;
    logic [XLEN-1:0] a_data;

    logic            b_valid;
    logic            b_ready;
    logic [RW-1:0]   b_rd;
    logic [XLEN-1:0] b_data;

    logic            RegWrite;
    logic [RW-1:0]   RD;
    logic [XLEN-1:0] WriteData;
    logic            init_done;

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output RegWrite, RD, WriteData, init_done
    );

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  RegWrite, RD, WriteData, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: clears all registers after reset, then round-robins A/B writebacks.
// Latency: accept edge N -> RegWrite/RD/WriteData visible in cycle N+1.
// Backpressure: ready is combinational from valid; no buffering, ready low during INIT and reset.
module regfile_wb_arbiter #(
    parameter int              XLEN       = 64,
    parameter int              NREG       = 32,
    parameter logic [XLEN-1:0] INIT_VALUE = '0
) (
    input  logic clk,
    input  logic reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int   RW   = $clog2(NREG);
    localparam logic GR_A = 1'b0;
    localparam logic GR_B = 1'b1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   idx, idx_nx;
    logic            last_grant, last_grant_nx;
    logic            reg_write_nx;
    logic [RW-1:0]   rd_nx;
    logic [XLEN-1:0] wdata_nx;
    logic            init_done_nx;
    logic            grant_a, grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            idx           <= '0;
            last_grant    <= GR_B;
            bus.RegWrite  <= 1'b0;
            bus.RD        <= '0;
            bus.WriteData <= '0;
            bus.init_done <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            last_grant    <= last_grant_nx;
            bus.RegWrite  <= reg_write_nx;
            bus.RD        <= rd_nx;
            bus.WriteData <= wdata_nx;
            bus.init_done <= init_done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        last_grant_nx = last_grant;
        reg_write_nx  = 1'b0;
        rd_nx         = bus.RD;
        wdata_nx      = bus.WriteData;
        init_done_nx  = bus.init_done;
        grant_a       = 1'b0;
        grant_b       = 1'b0;

        case (state)
            ST_INIT: begin
                reg_write_nx = 1'b1;
                rd_nx        = idx;
                wdata_nx     = INIT_VALUE;
                idx_nx       = idx + RW'(1);
                if (idx == RW'(NREG - 1)) begin
                    state_nx     = ST_RUN;
                    init_done_nx = 1'b1;
                    idx_nx       = '0;
                end
            end
            ST_RUN: begin
                // On a tie the requester that did not win last time goes first.
                grant_a = !reset && bus.a_valid && (!bus.b_valid || last_grant == GR_B);
                grant_b = !reset && bus.b_valid && (!bus.a_valid || last_grant == GR_A);
                if (grant_a) begin
                    reg_write_nx  = (bus.a_rd != '0);
                    rd_nx         = bus.a_rd;
                    wdata_nx      = bus.a_data;
                    last_grant_nx = GR_A;
                end else if (grant_b) begin
                    reg_write_nx  = (bus.b_rd != '0);
                    rd_nx         = bus.b_rd;
                    wdata_nx      = bus.b_data;
                    last_grant_nx = GR_B;
                end
            end
        endcase
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, arbitration, x0 writes, reset recovery.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .INIT_VALUE('0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_rd    = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_rd    = '0;
        bus.b_data  = '0;
        repeat (3) tick();

        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_rd", 64'(bus.RD), 64'd0);
        chk("rst_wdata", bus.WriteData, 64'd0);
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
        chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
        reset = 1'b0;

        // Full clear with both requesters pending
        for (int i = 0; i < NREG; i++) begin
            tick();
            chk("init_regwrite", 64'(bus.RegWrite), 64'd1);
            chk("init_rd", 64'(bus.RD), 64'(i));
            chk("init_wdata", bus.WriteData, 64'd0);
            chk("init_done", 64'(bus.init_done), (i == NREG - 1) ? 64'd1 : 64'd0);
            if (i < NREG - 1) begin
                chk("init_a_ready", 64'(bus.a_ready), 64'd0);
                chk("init_b_ready", 64'(bus.b_ready), 64'd0);
            end
            if (i == NREG - 2) begin
                bus.a_valid = 1'b0;
                bus.b_valid = 1'b0;
            end
        end

        // Single A write
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd5;
        bus.a_data  = 64'h1234;
        #1;
        chk("a_only_a_ready", 64'(bus.a_ready), 64'd1);
        chk("a_only_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        chk("a_only_regwrite", 64'(bus.RegWrite), 64'd1);
        chk("a_only_rd", 64'(bus.RD), 64'd5);
        chk("a_only_wdata", bus.WriteData, 64'h1234);
        bus.a_valid = 1'b0;
        #1;
        chk("a_idle_a_ready", 64'(bus.a_ready), 64'd0);
        tick();
        chk("a_after_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("a_after_rd_hold", 64'(bus.RD), 64'd5);
        chk("a_after_wdata_hold", bus.WriteData, 64'h1234);

        // B write to x0: handshake completes, no register write
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd0;
        bus.b_data  = 64'hFF;
        #1;
        chk("x0_b_ready", 64'(bus.b_ready), 64'd1);
        chk("x0_a_ready", 64'(bus.a_ready), 64'd0);
        tick();
        chk("x0_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("x0_rd", 64'(bus.RD), 64'd0);
        chk("x0_wdata", bus.WriteData, 64'hFF);
        bus.b_valid = 1'b0;

        // Both valid: last grant was B, so A,B,A,B
        bus.a_valid = 1'b1;
        bus.a_rd    = 5'd1;
        bus.a_data  = 64'hA1;
        bus.b_valid = 1'b1;
        bus.b_rd    = 5'd2;
        bus.b_data  = 64'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_a_ready", 64'(bus.a_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("tie_b_ready", 64'(bus.b_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
            chk("tie_not_both", 64'(bus.a_ready & bus.b_ready), 64'd0);
            tick();
            chk("tie_regwrite", 64'(bus.RegWrite), 64'd1);
            chk("tie_rd", 64'(bus.RD), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("tie_wdata", bus.WriteData, (k % 2 == 0) ? 64'hA1 : 64'hB2);
        end

        // Idle cycles must not move last_grant (still B)
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (2) tick();
        chk("idle_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("idle_rd_hold", 64'(bus.RD), 64'd2);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        chk("idle_tie_a_ready", 64'(bus.a_ready), 64'd1);
        chk("idle_tie_b_ready", 64'(bus.b_ready), 64'd0);

        // Reset during a RUN accept drops the write
        reset = 1'b1;
        #1;
        chk("rst_run_a_ready", 64'(bus.a_ready), 64'd0);
        tick();
        chk("rst_run_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_run_init_done", 64'(bus.init_done), 64'd0);
        chk("rst_run_rd", 64'(bus.RD), 64'd0);
        chk("rst_run_wdata", bus.WriteData, 64'd0);
        reset       = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // Clear restarts; interrupt it at RD==10
        for (int j = 0; j <= 10; j++) begin
            tick();
            chk("reinit_rd", 64'(bus.RD), 64'(j));
            chk("reinit_regwrite", 64'(bus.RegWrite), 64'd1);
        end
        reset = 1'b1;
        tick();
        chk("rst_init_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
        chk("rst_init_rd", 64'(bus.RD), 64'd0);
        reset = 1'b0;

        for (int j = 0; j < NREG; j++) begin
            tick();
            chk("final_init_rd", 64'(bus.RD), 64'(j));
            chk("final_init_regwrite", 64'(bus.RegWrite), 64'd1);
            chk("final_init_done", 64'(bus.init_done), (j == NREG - 1) ? 64'd1 : 64'd0);
        end
        tick();
        chk("final_idle_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("final_init_done_hold", 64'(bus.init_done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
